speed_cmd_arbiter: RTL and testbench

//  Shares the LR command input of the vdfsm speed FSM between two requesters: manual (driver) and auto (cruise).

---
 rtl/speed_cmd_arbiter_if.sv | 26 ++
 rtl/speed_cmd_arbiter.sv | 136 +++++++++++++
 tb/tb_speed_cmd_arbiter.sv | 245 ++++++++++++++++++++++++
 3 files changed

// File: rtl/speed_cmd_arbiter_if.sv
// Command bus between the manual/auto requesters and the speed command arbiter.
// Requests flow master -> slave; acks, LR pulse and shadow speed flow back.
interface speed_cmd_arbiter_if #(
    parameter int SPEED_W = 4
);
    logic               man_req;
    logic [1:0]         man_cmd;
    logic               auto_req;
    logic [1:0]         auto_cmd;
    logic               man_ack;
    logic               auto_ack;
    logic               cmd_rej;
    logic [1:0]         lr_out;
    logic [SPEED_W-1:0] speed_est;
    logic               busy;

    modport master (
        output man_req, man_cmd, auto_req, auto_cmd,
        input  man_ack, auto_ack, cmd_rej, lr_out, speed_est, busy
    );

    modport slave (
        input  man_req, man_cmd, auto_req, auto_cmd,
        output man_ack, auto_ack, cmd_rej, lr_out, speed_est, busy
    );
endinterface

// File: rtl/speed_cmd_arbiter.sv
// Purpose: arbitrates manual/auto speed commands onto vdfsm's LR input, range-checked against a shadow speed.
// Latency: request seen in IDLE at edge k -> ack/LR pulse in cycle k+1; accepts spaced GAP_CYCLES+2 apart.
// Backpressure: requests are held by the requester until ack; ignored while busy (ISSUE/REJECT/GAP).
// Optional build macro AUTO_STARVE_GUARD_EN forces an auto grant after STARVE_LIMIT manual grants.
module speed_cmd_arbiter #(
    parameter int SPEED_W      = 4,
    parameter int MAX_SPEED    = 15,
    parameter int GAP_CYCLES   = 2,
    parameter int STARVE_LIMIT = 3
) (
    input  logic                 clk,
    input  logic                 reset,
    speed_cmd_arbiter_if.slave   bus
);
    if (MAX_SPEED < 1 || MAX_SPEED >= (1 << SPEED_W) || GAP_CYCLES < 0 || STARVE_LIMIT < 1) begin : g_param_check
        $error("speed_cmd_arbiter: illegal parameter combination");
    end

    localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [GW-1:0]      GAP_LAST  = GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
    localparam logic [SPEED_W-1:0] SPEED_MAX = SPEED_W'(MAX_SPEED);

    typedef enum logic [1:0] {IDLE, ISSUE, REJECT, GAP} state_t;

    state_t             state, state_n;
    logic [GW-1:0]      gap_cnt, gap_n;
    logic [SPEED_W-1:0] speed_q, speed_n;
    logic [1:0]         lr_q, lr_n;
    logic               man_ack_q, man_ack_n;
    logic               auto_ack_q, auto_ack_n;
    logic               rej_q, rej_n;
    logic               busy_q, busy_n;

    logic               force_auto;
    logic               pick_auto;
    logic [1:0]         pick_cmd;
    logic               pick_up, pick_dn, pick_ok;

    assign pick_auto = bus.auto_req && (!bus.man_req || force_auto);
    assign pick_cmd  = pick_auto ? bus.auto_cmd : bus.man_cmd;
    assign pick_up   = (pick_cmd == 2'b01);
    assign pick_dn   = (pick_cmd == 2'b10);
    // Range check keeps the shadow speed inside [0, MAX_SPEED], so it never wraps.
    assign pick_ok   = (pick_up && speed_q != SPEED_MAX) || (pick_dn && speed_q != '0);

`ifdef AUTO_STARVE_GUARD_EN
    localparam int SW = $clog2(STARVE_LIMIT + 1);
    logic [SW-1:0] starve_cnt, starve_n;

    assign force_auto = bus.man_req && bus.auto_req && (starve_cnt == SW'(STARVE_LIMIT));

    always_comb begin
        starve_n = starve_cnt;
        if (state == IDLE) begin
            if (!bus.auto_req || pick_auto)
                starve_n = '0;
            else if (bus.man_req)
                starve_n = starve_cnt + SW'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) starve_cnt <= '0;
        else        starve_cnt <= starve_n;
    end
`else
    assign force_auto = 1'b0;
`endif

    always_comb begin
        state_n    = state;
        gap_n      = gap_cnt;
        speed_n    = speed_q;
        lr_n       = 2'b00;
        man_ack_n  = 1'b0;
        auto_ack_n = 1'b0;
        rej_n      = 1'b0;
        case (state)
            IDLE: begin
                if (bus.man_req || bus.auto_req) begin
                    man_ack_n  = !pick_auto;
                    auto_ack_n = pick_auto;
                    if (pick_ok) begin
                        state_n = ISSUE;
                        lr_n    = pick_cmd;
                        speed_n = pick_up ? speed_q + SPEED_W'(1) : speed_q - SPEED_W'(1);
                    end else begin
                        state_n = REJECT;
                        rej_n   = 1'b1;
                    end
                end
            end
            ISSUE: begin
                gap_n   = '0;
                state_n = (GAP_CYCLES > 0) ? GAP : IDLE;
            end
            REJECT: state_n = IDLE;
            GAP: begin
                if (gap_cnt == GAP_LAST) state_n = IDLE;
                else                     gap_n   = gap_cnt + GW'(1);
            end
            default: state_n = IDLE;
        endcase
        busy_n = (state_n != IDLE);
    end

    // Outputs are registered from next-state decode so they line up with the state they describe.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            gap_cnt    <= '0;
            speed_q    <= '0;
            lr_q       <= 2'b00;
            man_ack_q  <= 1'b0;
            auto_ack_q <= 1'b0;
            rej_q      <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state      <= state_n;
            gap_cnt    <= gap_n;
            speed_q    <= speed_n;
            lr_q       <= lr_n;
            man_ack_q  <= man_ack_n;
            auto_ack_q <= auto_ack_n;
            rej_q      <= rej_n;
            busy_q     <= busy_n;
        end
    end

    assign bus.lr_out    = lr_q;
    assign bus.man_ack   = man_ack_q;
    assign bus.auto_ack  = auto_ack_q;
    assign bus.cmd_rej   = rej_q;
    assign bus.speed_est = speed_q;
    assign bus.busy      = busy_q;
endmodule

// File: tb/tb_speed_cmd_arbiter.sv
// Bench for speed_cmd_arbiter: vector table of single requests plus hand sequences for
// arbitration, starvation guard and asynchronous reset; acks are scoreboarded in order.
module tb_speed_cmd_arbiter;
    localparam int SPEED_W      = 4;
    localparam int MAX_SPEED    = 15;
    localparam int GAP_CYCLES   = 2;
    localparam int STARVE_LIMIT = 2;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    speed_cmd_arbiter_if #(.SPEED_W(SPEED_W)) bus();

    speed_cmd_arbiter #(
        .SPEED_W(SPEED_W), .MAX_SPEED(MAX_SPEED),
        .GAP_CYCLES(GAP_CYCLES), .STARVE_LIMIT(STARVE_LIMIT)
    ) dut (
        .clk(clk), .reset(reset), .bus(bus)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic               is_auto;
        logic               rej;
        logic [1:0]         lr;
        logic [SPEED_W-1:0] speed;
    } exp_t;

    typedef struct {
        logic       is_auto;
        logic [1:0] cmd;
        exp_t       exp;
    } vec_t;

    exp_t sb[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;
    int   n_acks = 0;
    int   cyc    = 0;

    function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endfunction

    function automatic vec_t mk(logic a, logic [1:0] cmd, logic rej, logic [1:0] lr, int spd);
        vec_t v;
        v.is_auto   = a;
        v.cmd       = cmd;
        v.exp.is_auto = a;
        v.exp.rej   = rej;
        v.exp.lr    = lr;
        v.exp.speed = SPEED_W'(spd);
        return v;
    endfunction

    always @(posedge clk) cyc++;

    // Every ack cycle must match the oldest expectation; every other cycle keeps LR and reject low.
    always @(negedge clk) begin
        if (reset === 1'b1) begin
            if (bus.man_ack || bus.auto_ack) begin
                n_acks++;
                check("ack_exclusive", 32'(bus.man_ack & bus.auto_ack), 32'd0);
                if (sb.size() == 0) begin
                    check("unexpected_ack", 32'd1, 32'd0);
                end else begin
                    mon_e = sb.pop_front();
                    check("ack_record", 32'({bus.auto_ack, bus.cmd_rej, bus.lr_out, bus.speed_est}), 32'(mon_e));
                end
            end else begin
                check("idle_outputs", 32'({bus.cmd_rej, bus.lr_out}), 32'd0);
            end
        end
    end

    task automatic wait_ack(input logic is_auto, output int lat, output bit ok);
        ok  = 1'b0;
        lat = 0;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if ((is_auto ? bus.auto_ack : bus.man_ack) === 1'b1) begin
                lat = i;
                ok  = 1'b1;
                break;
            end
        end
        if (!ok) check("ack_timeout", 32'd0, 32'd1);
    endtask

    task automatic check_reset_outputs(input string name);
        check(name, 32'({bus.man_ack, bus.auto_ack, bus.cmd_rej, bus.lr_out, bus.speed_est, bus.busy}), 32'd0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        bus.man_req  = 1'b0;
        bus.auto_req = 1'b0;
        reset = 1'b0;
        #1;
        check_reset_outputs("reset_outputs");
        sb.delete();
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        @(negedge clk);
    endtask

    task automatic do_req(input vec_t v);
        int lat;
        int b;
        bit ok;
        sb.push_back(v.exp);
        if (v.is_auto) begin bus.auto_cmd = v.cmd; bus.auto_req = 1'b1; end
        else           begin bus.man_cmd  = v.cmd; bus.man_req  = 1'b1; end
        wait_ack(v.is_auto, lat, ok);
        if (ok) check("ack_latency", 32'(lat), 32'd1);
        b = bus.busy ? 1 : 0;
        @(posedge clk);
        #1;
        bus.man_req  = 1'b0;
        bus.auto_req = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.busy) b++;
            else break;
        end
        check("busy_cycles", 32'(b), v.exp.rej ? 32'd1 : 32'(GAP_CYCLES + 1));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1);
    end

    initial begin
        vec_t tbl[24];
        int   lat;
        int   t0;
        int   base;
        bit   ok;

        bus.man_req  = 1'b0;
        bus.man_cmd  = 2'b00;
        bus.auto_req = 1'b0;
        bus.auto_cmd = 2'b00;

        tbl[0]  = mk(1'b0, 2'b10, 1'b1, 2'b00, 0);
        tbl[1]  = mk(1'b0, 2'b11, 1'b1, 2'b00, 0);
        tbl[2]  = mk(1'b0, 2'b00, 1'b1, 2'b00, 0);
        for (int i = 3; i <= 17; i++) tbl[i] = mk(1'b0, 2'b01, 1'b0, 2'b01, i - 2);
        tbl[18] = mk(1'b0, 2'b01, 1'b1, 2'b00, 15);
        tbl[19] = mk(1'b0, 2'b10, 1'b0, 2'b10, 14);
        tbl[20] = mk(1'b1, 2'b01, 1'b0, 2'b01, 15);
        tbl[21] = mk(1'b1, 2'b01, 1'b1, 2'b00, 15);
        tbl[22] = mk(1'b1, 2'b10, 1'b0, 2'b10, 14);
        tbl[23] = mk(1'b1, 2'b00, 1'b1, 2'b00, 14);

        #2 reset = 1'b0;
        #1 check_reset_outputs("initial_reset");
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 24; i++) do_req(tbl[i]);
        check("table_sb_empty", 32'(sb.size()), 32'd0);

        // Simultaneous requests: manual first, auto one accept slot later.
        do_reset();
        sb.push_back(mk(1'b0, 2'b01, 1'b0, 2'b01, 1).exp);
        sb.push_back(mk(1'b1, 2'b01, 1'b0, 2'b01, 2).exp);
        bus.man_cmd = 2'b01; bus.auto_cmd = 2'b01;
        bus.man_req = 1'b1;  bus.auto_req = 1'b1;
        wait_ack(1'b0, lat, ok);
        t0 = cyc;
        @(posedge clk);
        #1 bus.man_req = 1'b0;
        wait_ack(1'b1, lat, ok);
        check("auto_after_man", 32'(cyc - t0), 32'(GAP_CYCLES + 2));
        @(posedge clk);
        #1 bus.auto_req = 1'b0;
        repeat (4) @(negedge clk);
        check("both_speed", 32'(bus.speed_est), 32'd2);
        check("both_sb_empty", 32'(sb.size()), 32'd0);

        // Both requests held: grant order depends on the starvation guard.
        do_reset();
`ifdef AUTO_STARVE_GUARD_EN
        sb.push_back(mk(1'b0, 2'b01, 1'b0, 2'b01, 1).exp);
        sb.push_back(mk(1'b0, 2'b01, 1'b0, 2'b01, 2).exp);
        sb.push_back(mk(1'b1, 2'b01, 1'b0, 2'b01, 3).exp);
        sb.push_back(mk(1'b0, 2'b01, 1'b0, 2'b01, 4).exp);
        sb.push_back(mk(1'b0, 2'b01, 1'b0, 2'b01, 5).exp);
        sb.push_back(mk(1'b1, 2'b01, 1'b0, 2'b01, 6).exp);
`else
        for (int i = 1; i <= 6; i++) sb.push_back(mk(1'b0, 2'b01, 1'b0, 2'b01, i).exp);
`endif
        base = n_acks;
        bus.man_cmd = 2'b01; bus.auto_cmd = 2'b01;
        bus.man_req = 1'b1;  bus.auto_req = 1'b1;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            #1;
            if (n_acks - base >= 6) break;
        end
        check("grant_count", 32'(n_acks - base), 32'd6);
        @(posedge clk);
        #1;
        bus.man_req  = 1'b0;
        bus.auto_req = 1'b0;
        repeat (4) @(negedge clk);
        check("starve_sb_empty", 32'(sb.size()), 32'd0);

        // Reset lands in GAP after an UP; a still-held request is reissued right after release.
        do_reset();
        sb.push_back(mk(1'b0, 2'b01, 1'b0, 2'b01, 1).exp);
        bus.man_cmd = 2'b01;
        bus.man_req = 1'b1;
        wait_ack(1'b0, lat, ok);
        @(negedge clk);
        check("gap_busy", 32'(bus.busy), 32'd1);
        check("gap_speed", 32'(bus.speed_est), 32'd1);
        reset = 1'b0;
        #1 check_reset_outputs("async_reset_in_gap");
        sb.push_back(mk(1'b0, 2'b01, 1'b0, 2'b01, 1).exp);
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        t0 = cyc;
        wait_ack(1'b0, lat, ok);
        check("reissue_latency", 32'(cyc - t0), 32'd1);
        @(posedge clk);
        #1 bus.man_req = 1'b0;
        repeat (4) @(negedge clk);
        check("reissue_sb_empty", 32'(sb.size()), 32'd0);
        check("final_idle", 32'({bus.busy, bus.lr_out}), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
